// File: rtl/gshare_bht.sv
// Gshare branch history table: PC XOR global history indexes a table of saturating counters.
// Combinational prediction; one-cycle RMW training; sweeps the table on reset/flush.

package config_pkg;
    typedef struct packed {
        logic        RVC;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{RVC: 1'b1, VLEN: 64};
endpackage

module gshare_bht #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned HIST_BITS       = 8,
    parameter int unsigned CTR_BITS        = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0]    vpc_i,
    output logic                       init_done_o,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [HIST_BITS-1:0]       pred_hist_o,
    input  logic                       spec_push_i,
    input  logic                       spec_taken_i,
    input  logic                       upd_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0]    upd_pc_i,
    input  logic [HIST_BITS-1:0]       upd_hist_i,
    input  logic                       upd_taken_i,
    input  logic                       upd_mispredict_i
);

    localparam int unsigned OFFSET   = CVA6Cfg.RVC ? 1 : 2;
    localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned COL_W    = (COL_BITS == 0) ? 1 : COL_BITS;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NR_ROWS - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t              state_q;
    logic [ROW_BITS-1:0] row_cnt_q;
    logic                init_done_q;
    logic [HIST_BITS-1:0] ghr_q;

    logic                valid_q [NR_ROWS][INSTR_PER_FETCH];
    logic [CTR_BITS-1:0] ctr_q   [NR_ROWS][INSTR_PER_FETCH];

    logic [ROW_BITS-1:0] pred_row;
    logic [ROW_BITS-1:0] upd_row;
    logic [COL_W-1:0]    upd_col;
    logic [CTR_BITS-1:0] upd_cur;
    logic [CTR_BITS-1:0] upd_nxt;
    logic                upd_en;
    logic                restore;
    logic                unused_bits;

    assign pred_row = ROW_BITS'(vpc_i >> (COL_BITS + OFFSET)) ^ ROW_BITS'(ghr_q);
    assign upd_row  = ROW_BITS'(upd_pc_i >> (COL_BITS + OFFSET)) ^ ROW_BITS'(upd_hist_i);
    assign upd_col  = (CVA6Cfg.RVC && INSTR_PER_FETCH > 1) ? COL_W'(upd_pc_i >> OFFSET) : '0;
    assign unused_bits = ^{vpc_i, upd_pc_i};

    // Training only happens once the sweep is done, so it never collides with init writes.
    assign upd_en  = upd_valid_i & ~debug_mode_i & init_done_q;
    assign restore = upd_valid_i & upd_mispredict_i;

    always_comb begin
        upd_cur = ctr_q[upd_row][upd_col];
        upd_nxt = upd_cur;
        if (upd_taken_i && upd_cur != CTR_MAX) begin
            upd_nxt = upd_cur + 1'b1;
        end else if (!upd_taken_i && upd_cur != '0) begin
            upd_nxt = upd_cur - 1'b1;
        end
    end

    // Table contents are undefined until swept, so both outputs are masked until then.
    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int c = 0; c < INSTR_PER_FETCH; c++) begin
            pred_valid_o[c] = valid_q[pred_row][c] & init_done_q;
            pred_taken_o[c] = ctr_q[pred_row][c][CTR_BITS-1] & init_done_q;
        end
    end

    assign init_done_o = init_done_q;
    assign pred_hist_o = ghr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == INIT) begin
                for (int c = 0; c < INSTR_PER_FETCH; c++) begin
                    valid_q[row_cnt_q][c] <= 1'b0;
                    ctr_q[row_cnt_q][c]   <= CTR_INIT;
                end
            end else if (upd_en) begin
                valid_q[upd_row][upd_col] <= 1'b1;
                ctr_q[upd_row][upd_col]   <= upd_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            row_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= INIT;
            row_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (row_cnt_q == ROW_LAST) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= READY;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    // A mispredict restore wins over a same-cycle speculative push.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ghr_q <= '0;
        end else if (restore) begin
            ghr_q <= {upd_hist_i[HIST_BITS-2:0], upd_taken_i};
        end else if (spec_push_i) begin
            ghr_q <= {ghr_q[HIST_BITS-2:0], spec_taken_i};
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht with default parameters (row = vpc[10:2], col = vpc[1]).
module tb_gshare_bht;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic [63:0] vpc_i = 64'h100;
    logic        init_done_o;
    logic [1:0]  pred_valid_o;
    logic [1:0]  pred_taken_o;
    logic [7:0]  pred_hist_o;
    logic        spec_push_i = 1'b0;
    logic        spec_taken_i = 1'b0;
    logic        upd_valid_i = 1'b0;
    logic [63:0] upd_pc_i = 64'h0;
    logic [7:0]  upd_hist_i = 8'h0;
    logic        upd_taken_i = 1'b0;
    logic        upd_mispredict_i = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    gshare_bht dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .debug_mode_i     (debug_mode_i),
        .vpc_i            (vpc_i),
        .init_done_o      (init_done_o),
        .pred_valid_o     (pred_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_hist_o      (pred_hist_o),
        .spec_push_i      (spec_push_i),
        .spec_taken_i     (spec_taken_i),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_hist_i       (upd_hist_i),
        .upd_taken_i      (upd_taken_i),
        .upd_mispredict_i (upd_mispredict_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [63:0] pc, input logic [7:0] hist, input logic taken, input int times);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_hist_i  = hist;
        upd_taken_i = taken;
        for (int i = 0; i < times; i++) tick();
        upd_valid_i = 1'b0;
    endtask

    int  n;
    logic saw_done;
    logic saw_valid;

    initial begin
        // reset and initial sweep
        tick();
        rst_i = 1'b0;
        chk("rst_init_done", init_done_o, 0);
        chk("rst_pred_valid", pred_valid_o, 0);
        chk("rst_pred_taken", pred_taken_o, 0);
        chk("rst_pred_hist", pred_hist_o, 0);
        n = 0;
        saw_valid = 1'b0;
        while (!init_done_o && n < 1000) begin
            tick();
            n++;
            if (!init_done_o && pred_valid_o != 2'b00) saw_valid = 1'b1;
        end
        chk("sweep_cycles", n, 512);
        chk("sweep_valid_gated", saw_valid, 0);

        // counter training at row 0x40 col 0
        chk("untrained_valid", pred_valid_o, 2'b00);
        upd_valid_i = 1'b1; upd_pc_i = 64'h100; upd_hist_i = 8'h0; upd_taken_i = 1'b1;
        #1;
        chk("same_cycle_pre_update", pred_valid_o, 2'b00);
        tick(); tick();
        upd_valid_i = 1'b0;
        chk("trained_valid", pred_valid_o, 2'b01);
        chk("trained_taken", pred_taken_o, 2'b01);
        train(64'h100, 8'h0, 1'b1, 3);
        train(64'h100, 8'h0, 1'b0, 1);
        chk("sat_high_then_dec", pred_taken_o, 2'b01);
        train(64'h100, 8'h0, 1'b0, 1);
        chk("dec_to_01", pred_taken_o, 2'b00);
        train(64'h100, 8'h0, 1'b0, 2);
        chk("dec_to_00", pred_taken_o, 2'b00);
        train(64'h100, 8'h0, 1'b1, 2);
        chk("sat_low_then_inc", pred_taken_o, 2'b01);

        // speculative history and hashed read of row 0x47
        train(64'h102, 8'h07, 1'b1, 1);
        spec_push_i = 1'b1; spec_taken_i = 1'b1;
        tick(); tick(); tick();
        spec_push_i = 1'b0;
        chk("spec_hist", pred_hist_o, 8'h07);
        chk("row47_valid", pred_valid_o, 2'b10);
        chk("row47_taken", pred_taken_o, 2'b10);

        // restore beats push; debug mode blocks training but not restore
        debug_mode_i = 1'b1;
        spec_push_i = 1'b1; spec_taken_i = 1'b1;
        upd_mispredict_i = 1'b1;
        train(64'h13E, 8'h05, 1'b0, 1);
        chk("restore_dbg_hist", pred_hist_o, 8'h0A);
        chk("restore_dbg_table", pred_valid_o, 2'b00);
        debug_mode_i = 1'b0;
        train(64'h13E, 8'h05, 1'b0, 1);
        spec_push_i = 1'b0;
        upd_mispredict_i = 1'b0;
        chk("restore_hist", pred_hist_o, 8'h0A);
        chk("restore_train_valid", pred_valid_o, 2'b10);
        chk("restore_train_taken", pred_taken_o, 2'b00);
        spec_push_i = 1'b1; spec_taken_i = 1'b0;
        tick();
        spec_push_i = 1'b0;
        chk("spec_not_taken", pred_hist_o, 8'h14);

        // flush, restart mid-sweep, updates during sweep are dropped
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_done", init_done_o, 0);
        chk("flush_hist", pred_hist_o, 8'h00);
        upd_valid_i = 1'b1; upd_pc_i = 64'h100; upd_hist_i = 8'h0; upd_taken_i = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (init_done_o) saw_done = 1'b1;
        end
        chk("mid_sweep_done", saw_done, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n = 0;
        saw_valid = 1'b0;
        while (!init_done_o && n < 1000) begin
            tick();
            n++;
            if (!init_done_o && pred_valid_o != 2'b00) saw_valid = 1'b1;
        end
        upd_valid_i = 1'b0;
        chk("reflush_cycles", n, 512);
        chk("reflush_valid_gated", saw_valid, 0);
        chk("post_sweep_row40", pred_valid_o, 2'b00);
        vpc_i = 64'h11E;
        #1;
        chk("post_sweep_row47", pred_valid_o, 2'b00);
        chk("post_sweep_hist", pred_hist_o, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/gshare_bht.md
GSHARE_BHT -- requirements
Module: gshare_bht

Interface
REQ-001 SHALL have parameter CVA6Cfg, config_pkg::cva6_cfg_empty, core config; RVC selects OFFSET=1, else OFFSET=2.
REQ-002 SHALL have parameter NR_ENTRIES, 1024, total counters, power of two.
REQ-003 SHALL have parameter INSTR_PER_FETCH, 2, predictions per fetch (columns); NR_ROWS=NR_ENTRIES/INSTR_PER_FETCH, ROW_BITS=log2(NR_ROWS), COL_BITS=log2(INSTR_PER_FETCH).
REQ-004 SHALL have parameter HIST_BITS, 8, global history length, 2..ROW_BITS.
REQ-005 SHALL have parameter CTR_BITS, 2, saturating counter width, 2..4.
REQ-006 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port flush_i  in  1  invalidate table, clear history.
REQ-009 SHALL have port debug_mode_i  in  1  suppress table training.
REQ-010 SHALL have port vpc_i  in  VLEN  fetch virtual PC.
REQ-011 SHALL have port init_done_o  out  1  table sweep complete.
REQ-012 SHALL have ports pred_valid_o / pred_taken_o  out  INSTR_PER_FETCH each  per-column prediction.
REQ-013 SHALL have port pred_hist_o  out  HIST_BITS  GHR used for this prediction (checkpoint).
REQ-014 SHALL have ports spec_push_i / spec_taken_i  in  1 / 1  frontend consumed a predicted conditional branch.
REQ-015 SHALL have ports upd_valid_i, upd_pc_i (VLEN), upd_hist_i (HIST_BITS), upd_taken_i, upd_mispredict_i  in  resolved-branch update.

Function
REQ-016 SHALL index: row = vpc_i[ROW_BITS+COL_BITS+OFFSET-1 : COL_BITS+OFFSET] XOR zero-extended GHR; column = vpc_i[COL_BITS+OFFSET-1 : OFFSET] (0 when !RVC).
REQ-017 SHALL drive predictions combinationally from vpc_i and current GHR: pred_valid_o[i]=entry valid, pred_taken_o[i]=counter MSB, all columns of the hashed row.
REQ-018 SHALL gate pred_valid_o to 0 while init_done_o=0.
REQ-019 SHALL apply update at row = upd_pc_i row bits XOR upd_hist_i, column from upd_pc_i; read-modify-write in one cycle; visible to predictions next cycle.
REQ-020 SHALL set entry valid on update; counter +1 on taken, -1 on not-taken, saturating at 0 and 2^CTR_BITS-1.
REQ-021 SHALL drop table update when debug_mode_i=1 or init_done_o=0.
REQ-022 SHALL update GHR with priority: (a) upd_valid_i & upd_mispredict_i: GHR <= {upd_hist_i[HIST_BITS-2:0], upd_taken_i}; (b) else spec_push_i: GHR <= {GHR[HIST_BITS-2:0], spec_taken_i}; (c) else hold.
REQ-023 SHALL apply GHR restore regardless of debug_mode_i; spec_push_i same cycle as restore is discarded.
REQ-024 SHALL implement FSM INIT/READY: INIT writes one row per cycle (all columns valid=0, counter=2^(CTR_BITS-1)-1), row counter 0..NR_ROWS-1, then READY; init_done_o=1 only in READY.
REQ-025 SHALL on flush_i in any state enter INIT with row counter 0 and GHR=0 next cycle; flush during INIT restarts sweep.
REQ-026 SHALL give prediction for entry updated same cycle the pre-update value.

Reset
REQ-027 SHALL on rst_i: FSM=INIT, row counter=0, GHR=0, init_done_o=0, pred_valid_o=0, pred_taken_o=0, pred_hist_o=0.
REQ-028 SHALL require no table contents reset except via sweep; rst_i overrides flush_i and updates.

Verification (defaults, RVC=1: row=vpc[10:2], col=vpc[1])
REQ-029 SHALL test: rst_i 1 cycle -> init_done_o 0 for exactly 512 cycles then 1; pred_valid_o=00 throughout.
REQ-030 SHALL test: after init, upd pc=0x100 hist=0 taken x2 -> row 0x40 col0 counter 01->10->11; vpc=0x100, GHR=0 -> pred_valid_o[0]=1, pred_taken_o[0]=1, pred_valid_o[1]=0.
REQ-031 SHALL test: 3 more taken updates -> counter stays 11; one not-taken -> 10, pred_taken_o[0]=1; two more not-taken -> 00, taken=0.
REQ-032 SHALL test: spec_push taken x3 from GHR=0 -> pred_hist_o=0x07; vpc=0x100 reads row 0x47.
REQ-033 SHALL test: GHR=0x07, same cycle spec_push taken and mispredict upd_hist=0x05 taken=0 -> GHR=0x0A; with debug_mode_i=1 GHR still 0x0A, table unchanged.
REQ-034 SHALL test: flush_i at sweep row 200 -> sweep restarts, init_done_o rises 512 cycles after flush; updates during sweep leave no valid entry.
